// File: rtl/fib_table_gen.sv
// Fibonacci table generator: rebuilds a DEPTH-entry table one entry per cycle,
// saturating at all-ones, and serves two independent 1-cycle-latency read ports.
module fib_table_gen #(
    parameter int W     = 32,
    parameter int DEPTH = 48,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          sat,
    input  logic          rd_req_a,
    input  logic [AW-1:0] rd_addr_a,
    output logic          rd_vld_a,
    output logic [W-1:0]  rd_data_a,
    output logic          rd_err_a,
    input  logic          rd_req_b,
    input  logic [AW-1:0] rd_addr_b,
    output logic          rd_vld_b,
    output logic [W-1:0]  rd_data_b,
    output logic          rd_err_b
);

    typedef enum logic {BUILD, READY} state_t;

    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] K_LAST  = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_k;
    logic [W-1:0]  r_f_prev;
    logic [W-1:0]  r_f_cur;
    logic          r_sat;
    logic [W-1:0]  r_mem [DEPTH];

    logic          w_last;
    logic          w_restart;
    logic [W:0]    w_sum;
    logic [W-1:0]  w_entry;
    logic          w_sat_set;
    logic          w_block;
    logic          w_oob_a;
    logic          w_oob_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= BUILD;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        case (r_state)
            BUILD: if (w_last) w_state_nxt = READY;
            READY: if (start) begin
                w_state_nxt = BUILD;
                w_restart   = 1'b1;
            end
            default: w_state_nxt = BUILD;
        endcase
    end

    // Entries 0 and 1 are seeds; later entries come from the running pair,
    // and once saturated every following entry stays pinned at all-ones.
    always_comb begin
        w_last    = (r_k == K_LAST);
        w_sum     = {1'b0, r_f_prev} + {1'b0, r_f_cur};
        w_entry   = '0;
        w_sat_set = 1'b0;
        if (r_k == '0) begin
            w_entry = '0;
        end else if (r_k == AW'(1)) begin
            w_entry = W'(1);
        end else if (w_sum[W] || r_sat) begin
            w_entry   = '1;
            w_sat_set = 1'b1;
        end else begin
            w_entry = w_sum[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k      <= '0;
            r_f_prev <= '0;
            r_f_cur  <= '0;
            r_sat    <= 1'b0;
        end else if (r_state == BUILD) begin
            r_k      <= w_last ? '0 : r_k + AW'(1);
            r_f_prev <= r_f_cur;
            r_f_cur  <= w_entry;
            if (w_sat_set) r_sat <= 1'b1;
        end else if (w_restart) begin
            r_k   <= '0;
            r_sat <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && r_state == BUILD) r_mem[r_k] <= w_entry;
    end

    // A start accepted this cycle already makes the table invalid for reads.
    assign w_block = (r_state == BUILD) || start;
    assign w_oob_a = ({1'b0, rd_addr_a} >= DEPTH_X);
    assign w_oob_b = ({1'b0, rd_addr_b} >= DEPTH_X);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_a  <= 1'b0;
            rd_data_a <= '0;
            rd_err_a  <= 1'b0;
        end else if (rd_req_a) begin
            rd_vld_a <= 1'b1;
            if (w_block || w_oob_a) begin
                rd_data_a <= '0;
                rd_err_a  <= 1'b1;
            end else begin
                rd_data_a <= r_mem[rd_addr_a];
                rd_err_a  <= 1'b0;
            end
        end else begin
            rd_vld_a <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_b  <= 1'b0;
            rd_data_b <= '0;
            rd_err_b  <= 1'b0;
        end else if (rd_req_b) begin
            rd_vld_b <= 1'b1;
            if (w_block || w_oob_b) begin
                rd_data_b <= '0;
                rd_err_b  <= 1'b1;
            end else begin
                rd_data_b <= r_mem[rd_addr_b];
                rd_err_b  <= 1'b0;
            end
        end else begin
            rd_vld_b <= 1'b0;
        end
    end

    assign busy = (r_state == BUILD);
    assign sat  = r_sat;

endmodule

// File: tb/tb_fib_table_gen.sv
// Directed bench for fib_table_gen: default 32-bit table plus a 16-bit, 33-entry
// instance that must saturate.
`timescale 1ns/1ps
module tb_fib_table_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy, sat;
    logic        rdReqA, rdReqB;
    logic [5:0]  rdAddrA, rdAddrB;
    logic        rdVldA, rdVldB, rdErrA, rdErrB;
    logic [31:0] rdDataA, rdDataB;

    logic        start16;
    logic        busy16, sat16;
    logic        rdReqA16, rdReqB16;
    logic [5:0]  rdAddrA16, rdAddrB16;
    logic        rdVldA16, rdVldB16, rdErrA16, rdErrB16;
    logic [15:0] rdDataA16, rdDataB16;

    int checkCount = 0;
    int passCount  = 0;

    fib_table_gen dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .sat(sat),
        .rd_req_a(rdReqA), .rd_addr_a(rdAddrA), .rd_vld_a(rdVldA),
        .rd_data_a(rdDataA), .rd_err_a(rdErrA),
        .rd_req_b(rdReqB), .rd_addr_b(rdAddrB), .rd_vld_b(rdVldB),
        .rd_data_b(rdDataB), .rd_err_b(rdErrB)
    );

    fib_table_gen #(.W(16), .DEPTH(33), .AW(6)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .busy(busy16), .sat(sat16),
        .rd_req_a(rdReqA16), .rd_addr_a(rdAddrA16), .rd_vld_a(rdVldA16),
        .rd_data_a(rdDataA16), .rd_err_a(rdErrA16),
        .rd_req_b(rdReqB16), .rd_addr_b(rdAddrB16), .rd_vld_b(rdVldB16),
        .rd_data_b(rdDataB16), .rd_err_b(rdErrB16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick(2);
        checkCount++; if (busy !== 1'b1) $display("[TB] FAIL reset_busy: got %0b want 1", busy); else passCount++;
        checkCount++; if (sat !== 1'b0) $display("[TB] FAIL reset_sat: got %0b want 0", sat); else passCount++;
        checkCount++; if ({rdVldA, rdErrA, rdVldB, rdErrB} !== 4'b0000)
            $display("[TB] FAIL reset_vld_err: got %b want 0000", {rdVldA, rdErrA, rdVldB, rdErrB}); else passCount++;
        checkCount++; if (rdDataA !== 32'd0 || rdDataB !== 32'd0)
            $display("[TB] FAIL reset_data: got %0d/%0d want 0/0", rdDataA, rdDataB); else passCount++;
    endtask

    task automatic test_build;
        rst = 1'b1;
        tick(47);
        checkCount++; if (busy !== 1'b1) $display("[TB] FAIL build_busy_47: got %0b want 1", busy); else passCount++;
        tick(1);
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL build_busy_48: got %0b want 0", busy); else passCount++;
        checkCount++; if (sat !== 1'b0) $display("[TB] FAIL build_sat: got %0b want 0", sat); else passCount++;
        rdReqA = 1'b1; rdAddrA = 6'd47;
        rdReqB = 1'b1; rdAddrB = 6'd32;
        tick(1);
        rdReqA = 1'b0; rdReqB = 1'b0;
        checkCount++; if (rdVldA !== 1'b1 || rdErrA !== 1'b0 || rdDataA !== 32'd2971215073)
            $display("[TB] FAIL read_a_47: got vld=%0b err=%0b data=%0d want 1/0/2971215073", rdVldA, rdErrA, rdDataA); else passCount++;
        checkCount++; if (rdVldB !== 1'b1 || rdErrB !== 1'b0 || rdDataB !== 32'd2178309)
            $display("[TB] FAIL read_b_32: got vld=%0b err=%0b data=%0d want 1/0/2178309", rdVldB, rdErrB, rdDataB); else passCount++;
        tick(1);
        checkCount++; if (rdVldA !== 1'b0 || rdDataA !== 32'd2971215073 || rdErrA !== 1'b0)
            $display("[TB] FAIL read_a_hold: got vld=%0b err=%0b data=%0d want 0/0/2971215073", rdVldA, rdErrA, rdDataA); else passCount++;
    endtask

    task automatic test_saturation;
        checkCount++; if (busy16 !== 1'b0 || sat16 !== 1'b1)
            $display("[TB] FAIL sat16_flags: got busy=%0b sat=%0b want 0/1", busy16, sat16); else passCount++;
        rdReqA16 = 1'b1; rdAddrA16 = 6'd24;
        rdReqB16 = 1'b1; rdAddrB16 = 6'd25;
        tick(1);
        checkCount++; if (rdVldA16 !== 1'b1 || rdErrA16 !== 1'b0 || rdDataA16 !== 16'd46368)
            $display("[TB] FAIL sat16_idx24: got vld=%0b err=%0b data=%0d want 1/0/46368", rdVldA16, rdErrA16, rdDataA16); else passCount++;
        checkCount++; if (rdVldB16 !== 1'b1 || rdErrB16 !== 1'b0 || rdDataB16 !== 16'd65535)
            $display("[TB] FAIL sat16_idx25: got vld=%0b err=%0b data=%0d want 1/0/65535", rdVldB16, rdErrB16, rdDataB16); else passCount++;
        rdReqA16 = 1'b0; rdAddrB16 = 6'd32;
        tick(1);
        rdReqB16 = 1'b0;
        checkCount++; if (rdVldB16 !== 1'b1 || rdErrB16 !== 1'b0 || rdDataB16 !== 16'd65535)
            $display("[TB] FAIL sat16_idx32: got vld=%0b err=%0b data=%0d want 1/0/65535", rdVldB16, rdErrB16, rdDataB16); else passCount++;
        checkCount++; if (rdVldA16 !== 1'b0) $display("[TB] FAIL sat16_no_req: got vld=%0b want 0", rdVldA16); else passCount++;
    endtask

    task automatic test_start_rebuild;
        start = 1'b1;
        rdReqA = 1'b1; rdAddrA = 6'd10;
        tick(1);
        start = 1'b0;
        checkCount++; if (busy !== 1'b1) $display("[TB] FAIL start_busy: got %0b want 1", busy); else passCount++;
        checkCount++; if (rdVldA !== 1'b1 || rdErrA !== 1'b1 || rdDataA !== 32'd0)
            $display("[TB] FAIL start_read_err: got vld=%0b err=%0b data=%0d want 1/1/0", rdVldA, rdErrA, rdDataA); else passCount++;
        rdAddrA = 6'd5;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        rdReqA = 1'b0;
        checkCount++; if (rdVldA !== 1'b1 || rdErrA !== 1'b1 || rdDataA !== 32'd0)
            $display("[TB] FAIL busy_read_a5: got vld=%0b err=%0b data=%0d want 1/1/0", rdVldA, rdErrA, rdDataA); else passCount++;
        tick(46);
        checkCount++; if (busy !== 1'b1) $display("[TB] FAIL rebuild_busy_47: got %0b want 1", busy); else passCount++;
        tick(1);
        checkCount++; if (busy !== 1'b0 || sat !== 1'b0)
            $display("[TB] FAIL rebuild_done: got busy=%0b sat=%0b want 0/0", busy, sat); else passCount++;
        rdReqA = 1'b1; rdAddrA = 6'd10;
        rdReqB = 1'b1; rdAddrB = 6'd50;
        tick(1);
        rdReqA = 1'b0; rdReqB = 1'b0;
        checkCount++; if (rdVldA !== 1'b1 || rdErrA !== 1'b0 || rdDataA !== 32'd55)
            $display("[TB] FAIL rebuild_idx10: got vld=%0b err=%0b data=%0d want 1/0/55", rdVldA, rdErrA, rdDataA); else passCount++;
        checkCount++; if (rdVldB !== 1'b1 || rdErrB !== 1'b1 || rdDataB !== 32'd0)
            $display("[TB] FAIL oob_b_50: got vld=%0b err=%0b data=%0d want 1/1/0", rdVldB, rdErrB, rdDataB); else passCount++;
    endtask

    task automatic test_back_to_back;
        int gotA = 0;
        int gotB = 0;
        rdReqA = 1'b1; rdAddrA = 6'd12;
        rdReqB = 1'b1; rdAddrB = 6'd12;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (i == 9) begin
                rdReqA = 1'b0; rdReqB = 1'b0;
            end
            if (rdVldA === 1'b1 && rdErrA === 1'b0 && rdDataA === 32'd144) gotA++;
            if (rdVldB === 1'b1 && rdErrB === 1'b0 && rdDataB === 32'd144) gotB++;
        end
        checkCount++; if (gotA !== 10) $display("[TB] FAIL b2b_a_count: got %0d want 10", gotA); else passCount++;
        checkCount++; if (gotB !== 10) $display("[TB] FAIL b2b_b_count: got %0d want 10", gotB); else passCount++;
        tick(1);
        checkCount++; if (rdVldA !== 1'b0 || rdVldB !== 1'b0 || rdDataA !== 32'd144)
            $display("[TB] FAIL b2b_tail: got vldA=%0b vldB=%0b dataA=%0d want 0/0/144", rdVldA, rdVldB, rdDataA); else passCount++;
    endtask

    task automatic test_reset_mid_build;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(20);
        rdReqA = 1'b1; rdAddrA = 6'd3;
        #2;
        rst = 1'b0;
        #1;
        checkCount++; if (busy !== 1'b1 || sat !== 1'b0)
            $display("[TB] FAIL midrst_flags: got busy=%0b sat=%0b want 1/0", busy, sat); else passCount++;
        tick(3);
        rdReqA = 1'b0;
        checkCount++; if ({rdVldA, rdErrA, rdVldB, rdErrB} !== 4'b0000 || rdDataA !== 32'd0 || rdDataB !== 32'd0)
            $display("[TB] FAIL midrst_outputs: got vld/err=%b dataA=%0d dataB=%0d want 0000/0/0",
                     {rdVldA, rdErrA, rdVldB, rdErrB}, rdDataA, rdDataB); else passCount++;
        rst = 1'b1;
        tick(47);
        checkCount++; if (busy !== 1'b1) $display("[TB] FAIL midrst_busy_47: got %0b want 1", busy); else passCount++;
        tick(1);
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy_48: got %0b want 0", busy); else passCount++;
        rdReqA = 1'b1; rdAddrA = 6'd1;
        rdReqB = 1'b1; rdAddrB = 6'd2;
        tick(1);
        rdReqA = 1'b0; rdReqB = 1'b0;
        checkCount++; if (rdVldA !== 1'b1 || rdErrA !== 1'b0 || rdDataA !== 32'd1)
            $display("[TB] FAIL midrst_idx1: got vld=%0b err=%0b data=%0d want 1/0/1", rdVldA, rdErrA, rdDataA); else passCount++;
        checkCount++; if (rdVldB !== 1'b1 || rdErrB !== 1'b0 || rdDataB !== 32'd1)
            $display("[TB] FAIL midrst_idx2: got vld=%0b err=%0b data=%0d want 1/0/1", rdVldB, rdErrB, rdDataB); else passCount++;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0;
        rdReqA = 1'b0; rdAddrA = '0; rdReqB = 1'b0; rdAddrB = '0;
        start16 = 1'b0;
        rdReqA16 = 1'b0; rdAddrA16 = '0; rdReqB16 = 1'b0; rdAddrB16 = '0;
        #1;
        test_reset;
        test_build;
        test_saturation;
        test_start_rebuild;
        test_back_to_back;
        test_reset_mid_build;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
